// File: rtl/wb_regfile_if.sv
// Bus bundle for wb_regfile: the memory-stage writeback inputs and two combinational read ports.
interface wb_regfile_if #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5
);
  logic              stall_i;
  logic              flush_i;
  logic [ADDR_W-1:0] wd_i;
  logic              wreg_i;
  logic [DATA_W-1:0] wdata_i;
  logic              re1_i;
  logic [ADDR_W-1:0] raddr1_i;
  logic [DATA_W-1:0] rdata1_o;
  logic              re2_i;
  logic [ADDR_W-1:0] raddr2_i;
  logic [DATA_W-1:0] rdata2_o;
  logic              wb_busy_o;

  modport slave (
    input  stall_i, flush_i, wd_i, wreg_i, wdata_i,
    input  re1_i, raddr1_i, re2_i, raddr2_i,
    output rdata1_o, rdata2_o, wb_busy_o
  );

  modport master (
    output stall_i, flush_i, wd_i, wreg_i, wdata_i,
    output re1_i, raddr1_i, re2_i, raddr2_i,
    input  rdata1_o, rdata2_o, wb_busy_o
  );
endinterface

// File: rtl/wb_regfile.sv
// Register file with a one-entry writeback latch in front of the array; register 0 is hardwired to zero.
// Optional macro WB_BYPASS_EN forwards the pending latch value to matching read ports.
module wb_regfile #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5
) (
  input  logic        clk,
  input  logic        rst,
  wb_regfile_if.slave bus
);
  localparam int NREG = 1 << ADDR_W;

  logic [DATA_W-1:0] r_regs [NREG];
  logic [ADDR_W-1:0] r_wb_wd;
  logic              r_wb_wreg;
  logic [DATA_W-1:0] r_wb_wdata;

  logic              w_wb_busy;
  logic [DATA_W-1:0] w_rdata1;
  logic [DATA_W-1:0] w_rdata2;

  assign w_wb_busy = r_wb_wreg && (r_wb_wd != '0);

  // The array write is driven from the latch, so a stalled latch rewrites the same value harmlessly.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NREG; i++) begin
        r_regs[i] <= '0;
      end
      r_wb_wd    <= '0;
      r_wb_wreg  <= 1'b0;
      r_wb_wdata <= '0;
    end else begin
      if (bus.flush_i) begin
        r_wb_wreg <= 1'b0;
      end else if (!bus.stall_i) begin
        r_wb_wd    <= bus.wd_i;
        r_wb_wreg  <= bus.wreg_i;
        r_wb_wdata <= bus.wdata_i;
      end
      if (w_wb_busy) begin
        r_regs[r_wb_wd] <= r_wb_wdata;
      end
    end
  end

  always_comb begin
    w_rdata1 = '0;
    if (!rst && bus.re1_i && (bus.raddr1_i != '0)) begin
`ifdef WB_BYPASS_EN
      if (r_wb_wreg && (bus.raddr1_i == r_wb_wd)) begin
        w_rdata1 = r_wb_wdata;
      end else begin
        w_rdata1 = r_regs[bus.raddr1_i];
      end
`else
      w_rdata1 = r_regs[bus.raddr1_i];
`endif
    end
  end

  always_comb begin
    w_rdata2 = '0;
    if (!rst && bus.re2_i && (bus.raddr2_i != '0)) begin
`ifdef WB_BYPASS_EN
      if (r_wb_wreg && (bus.raddr2_i == r_wb_wd)) begin
        w_rdata2 = r_wb_wdata;
      end else begin
        w_rdata2 = r_regs[bus.raddr2_i];
      end
`else
      w_rdata2 = r_regs[bus.raddr2_i];
`endif
    end
  end

  assign bus.rdata1_o  = w_rdata1;
  assign bus.rdata2_o  = w_rdata2;
  assign bus.wb_busy_o = w_wb_busy && !rst;
endmodule

// File: tb/tb_wb_regfile.sv
// Directed self-checking bench for wb_regfile; expectations follow WB_BYPASS_EN when defined.
module tb_wb_regfile;
  logic clk;
  logic rst;
  int   n_pass;
  int   n_total;

  wb_regfile_if #(.DATA_W(32), .ADDR_W(5)) bus ();

  wb_regfile #(.DATA_W(32), .ADDR_W(5)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    bus.wd_i = 5'd5; bus.wreg_i = 1'b1; bus.wdata_i = 32'hCAFE_F00D;
    bus.re1_i = 1'b1; bus.raddr1_i = 5'd5;
    bus.re2_i = 1'b1; bus.raddr2_i = 5'd5;
    tick(); tick();
    n_total++; if (bus.rdata1_o !== 32'h0) $display("FAIL rst_rdata1 got %h want %h", bus.rdata1_o, 32'h0); else n_pass++;
    n_total++; if (bus.rdata2_o !== 32'h0) $display("FAIL rst_rdata2 got %h want %h", bus.rdata2_o, 32'h0); else n_pass++;
    n_total++; if (bus.wb_busy_o !== 1'b0) $display("FAIL rst_busy got %b want 0", bus.wb_busy_o); else n_pass++;
    bus.wreg_i = 1'b0;
    rst = 1'b0;
    // Complete a write to r5, then reset one cycle.
    bus.wd_i = 5'd5; bus.wreg_i = 1'b1; bus.wdata_i = 32'h0000_1234;
    tick();
    bus.wreg_i = 1'b0;
    tick();
    n_total++; if (bus.rdata1_o !== 32'h0000_1234) $display("FAIL r5_written got %h want %h", bus.rdata1_o, 32'h0000_1234); else n_pass++;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    #1;
    n_total++; if (bus.rdata1_o !== 32'h0) $display("FAIL r5_after_rst got %h want %h", bus.rdata1_o, 32'h0); else n_pass++;
    n_total++; if (bus.wb_busy_o !== 1'b0) $display("FAIL busy_after_rst got %b want 0", bus.wb_busy_o); else n_pass++;
  endtask

  task automatic test_basic_write();
    bus.re1_i = 1'b1; bus.raddr1_i = 5'd3;
    bus.wd_i = 5'd3; bus.wreg_i = 1'b1; bus.wdata_i = 32'hDEAD_BEEF;
    tick();
    bus.wreg_i = 1'b0; bus.wdata_i = 32'h0;
    #1;
    n_total++; if (bus.wb_busy_o !== 1'b1) $display("FAIL basic_busy got %b want 1", bus.wb_busy_o); else n_pass++;
`ifdef WB_BYPASS_EN
    n_total++; if (bus.rdata1_o !== 32'hDEAD_BEEF) $display("FAIL basic_bypass got %h want %h", bus.rdata1_o, 32'hDEAD_BEEF); else n_pass++;
`else
    n_total++; if (bus.rdata1_o !== 32'h0) $display("FAIL basic_old_value got %h want %h", bus.rdata1_o, 32'h0); else n_pass++;
`endif
    tick();
    n_total++; if (bus.rdata1_o !== 32'hDEAD_BEEF) $display("FAIL basic_array got %h want %h", bus.rdata1_o, 32'hDEAD_BEEF); else n_pass++;
    n_total++; if (bus.wb_busy_o !== 1'b0) $display("FAIL basic_idle got %b want 0", bus.wb_busy_o); else n_pass++;
  endtask

  task automatic test_r0_protect();
    bus.re1_i = 1'b1; bus.raddr1_i = 5'd0;
    bus.wd_i = 5'd0; bus.wreg_i = 1'b1; bus.wdata_i = 32'hFFFF_FFFF;
    tick();
    bus.wreg_i = 1'b0;
    #1;
    n_total++; if (bus.wb_busy_o !== 1'b0) $display("FAIL r0_busy got %b want 0", bus.wb_busy_o); else n_pass++;
    n_total++; if (bus.rdata1_o !== 32'h0) $display("FAIL r0_read got %h want %h", bus.rdata1_o, 32'h0); else n_pass++;
    tick();
    bus.raddr1_i = 5'd3;
    #1;
    n_total++; if (bus.rdata1_o !== 32'hDEAD_BEEF) $display("FAIL r0_array_unchanged got %h want %h", bus.rdata1_o, 32'hDEAD_BEEF); else n_pass++;
  endtask

  task automatic test_stall_flush();
    bus.re1_i = 1'b1; bus.raddr1_i = 5'd7;
    bus.wd_i = 5'd7; bus.wreg_i = 1'b1; bus.wdata_i = 32'h0000_0055;
    tick();
    bus.wd_i = 5'd0; bus.wreg_i = 1'b0; bus.wdata_i = 32'h0;
    bus.stall_i = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      n_total++; if (bus.wb_busy_o !== 1'b1) $display("FAIL stall_busy[%0d] got %b want 1", i, bus.wb_busy_o); else n_pass++;
      n_total++; if (bus.rdata1_o !== 32'h0000_0055) $display("FAIL stall_r7[%0d] got %h want %h", i, bus.rdata1_o, 32'h55); else n_pass++;
    end
    bus.flush_i = 1'b1;
    tick();
    bus.flush_i = 1'b0; bus.stall_i = 1'b0;
    #1;
    n_total++; if (bus.wb_busy_o !== 1'b0) $display("FAIL flush_busy got %b want 0", bus.wb_busy_o); else n_pass++;
    n_total++; if (bus.rdata1_o !== 32'h0000_0055) $display("FAIL flush_r7 got %h want %h", bus.rdata1_o, 32'h55); else n_pass++;
  endtask

  task automatic test_dual_read();
    bus.wd_i = 5'd1; bus.wreg_i = 1'b1; bus.wdata_i = 32'h0000_0011;
    tick();
    bus.wd_i = 5'd2; bus.wdata_i = 32'h0000_0022;
    tick();
    bus.wreg_i = 1'b0;
    tick();
    bus.re1_i = 1'b1; bus.raddr1_i = 5'd1;
    bus.re2_i = 1'b1; bus.raddr2_i = 5'd2;
    #1;
    n_total++; if (bus.rdata1_o !== 32'h11) $display("FAIL dual_p1 got %h want %h", bus.rdata1_o, 32'h11); else n_pass++;
    n_total++; if (bus.rdata2_o !== 32'h22) $display("FAIL dual_p2 got %h want %h", bus.rdata2_o, 32'h22); else n_pass++;
    bus.raddr2_i = 5'd1;
    #1;
    n_total++; if (bus.rdata2_o !== 32'h11) $display("FAIL dual_same_addr got %h want %h", bus.rdata2_o, 32'h11); else n_pass++;
    bus.re2_i = 1'b0;
    #1;
    n_total++; if (bus.rdata2_o !== 32'h0) $display("FAIL re2_off got %h want %h", bus.rdata2_o, 32'h0); else n_pass++;
    n_total++; if (bus.rdata1_o !== 32'h11) $display("FAIL p1_indep got %h want %h", bus.rdata1_o, 32'h11); else n_pass++;
    bus.re1_i = 1'b0;
    #1;
    n_total++; if (bus.rdata1_o !== 32'h0) $display("FAIL re1_off got %h want %h", bus.rdata1_o, 32'h0); else n_pass++;
  endtask

  task automatic test_reset_mid_write();
    bus.re1_i = 1'b1; bus.raddr1_i = 5'd9;
    bus.re2_i = 1'b1; bus.raddr2_i = 5'd3;
    bus.wd_i = 5'd9; bus.wreg_i = 1'b1; bus.wdata_i = 32'h0000_ABCD;
    tick();
    bus.wreg_i = 1'b0;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    tick(); tick();
    n_total++; if (bus.rdata1_o !== 32'h0) $display("FAIL midrst_r9 got %h want %h", bus.rdata1_o, 32'h0); else n_pass++;
    n_total++; if (bus.wb_busy_o !== 1'b0) $display("FAIL midrst_busy got %b want 0", bus.wb_busy_o); else n_pass++;
    n_total++; if (bus.rdata2_o !== 32'h0) $display("FAIL midrst_r3_cleared got %h want %h", bus.rdata2_o, 32'h0); else n_pass++;
  endtask

  initial begin
    n_pass = 0;
    n_total = 0;
    rst = 1'b1;
    bus.stall_i = 1'b0; bus.flush_i = 1'b0;
    bus.wd_i = '0; bus.wreg_i = 1'b0; bus.wdata_i = '0;
    bus.re1_i = 1'b0; bus.raddr1_i = '0;
    bus.re2_i = 1'b0; bus.raddr2_i = '0;
    test_reset();
    test_basic_write();
    test_r0_protect();
    test_stall_flush();
    test_dual_read();
    test_reset_mid_write();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule

// File: doc/wb_regfile.md
WB_REGFILE -- requirements
Module: wb_regfile

Interface
REQ-001 The block SHALL take parameter DATA_W, default 32, as the register data width.
REQ-002 The block SHALL take parameter ADDR_W, default 5, as the register address width; the register count is 2**ADDR_W.
REQ-003 The block SHALL have one clock and a synchronous, active-high reset: clk  input  1  rising-edge clock.
REQ-004 rst  input  1  synchronous active-high reset (`RstEnable = 1).
REQ-005 stall_i  input  1  hold the writeback latch.
REQ-006 flush_i  input  1  invalidate the writeback latch.
REQ-007 wd_i  input  ADDR_W  destination register from the memory stage.
REQ-008 wreg_i  input  1  write enable from the memory stage.
REQ-009 wdata_i  input  DATA_W  write data from the memory stage.
REQ-010 re1_i  input  1  read port 1 enable.
REQ-011 raddr1_i  input  ADDR_W  read port 1 address.
REQ-012 rdata1_o  output  DATA_W  read port 1 data, combinational.
REQ-013 re2_i  input  1  read port 2 enable.
REQ-014 raddr2_i  input  ADDR_W  read port 2 address.
REQ-015 rdata2_o  output  DATA_W  read port 2 data, combinational.
REQ-016 wb_busy_o  output  1  latch holds a pending write (wreg set, address nonzero).

Function
REQ-017 Writeback latch (wb_wd, wb_wreg, wb_wdata) SHALL capture wd_i/wreg_i/wdata_i at each rising edge where rst=0, flush_i=0 and stall_i=0.
REQ-018 When stall_i=1 and flush_i=0, the latch SHALL hold its contents.
REQ-019 When flush_i=1, wb_wreg SHALL clear to 0 at the edge, regardless of stall_i (flush beats stall).
REQ-020 At each edge with rst=0, wb_wreg=1 and wb_wd!=0, array[wb_wd] SHALL load wb_wdata; a repeated write while stalled is idempotent.
REQ-021 Write latency: data presented on wd_i at edge N is in the latch after N and in the array after N+1.
REQ-022 Register 0 SHALL read as zero and SHALL never be written.
REQ-023 Read priority per port: rst=1 -> zero; re=0 -> zero; address 0 -> zero; bypass hit (REQ-030) -> wb_wdata; else array contents.
REQ-024 Both read ports SHALL be independent; identical addresses SHALL return identical data.
REQ-025 wb_busy_o SHALL equal wb_wreg AND (wb_wd != 0).
REQ-026 Write data SHALL be stored full-width with no sign or zero modification.

Reset
REQ-027 While rst=1 at a rising edge, all array entries SHALL clear to zero and wb_wd, wb_wreg, wb_wdata SHALL clear to zero, overriding stall_i and flush_i.
REQ-028 While rst=1, rdata1_o, rdata2_o and wb_busy_o SHALL read 0.
REQ-029 Reset asserted mid-write SHALL discard the pending latch write; after reset release, no stale write SHALL reach the array.

Configuration
REQ-030 With WB_BYPASS_EN defined, a read port whose enabled, nonzero address equals wb_wd while wb_wreg=1 SHALL return wb_wdata in the same cycle.
REQ-031 Without WB_BYPASS_EN, reads SHALL return array contents only; a read of a register pending in the latch returns its old value until the array write completes.

Verification
REQ-032 Reset: write r5=0x1234 and complete it, assert rst one cycle -> r5 reads 0x00000000, wb_busy_o=0.
REQ-033 Basic write/read: wd_i=3, wreg_i=1, wdata_i=0xDEADBEEF at edge N -> with raddr1_i=3, re1_i=1, rdata1_o=0xDEADBEEF after edge N+1 in both configs; with WB_BYPASS_EN, also after edge N.
REQ-034 r0 protection: write wd_i=0, wdata_i=0xFFFFFFFF -> rdata1_o=0 for raddr1_i=0, wb_busy_o=0, array unchanged.
REQ-035 Stall then flush: latch holds r7=0x55 with stall_i=1 for 3 cycles -> r7=0x55 and wb_busy_o=1 throughout; flush_i=1 with stall_i=1 -> wb_busy_o=0 next cycle, r7 still 0x55.
REQ-036 Dual read and disable: r1=0x11, r2=0x22; raddr1_i=1, raddr2_i=2 -> 0x11/0x22; re2_i=0 -> rdata2_o=0.
REQ-037 Reset mid-write: latch holds r9=0xABCD, rst=1 at the next edge -> r9 reads 0, wb_busy_o=0 after reset release.
